// File: rtl/serial_alu_ctrl.sv
// ============================================================================
// Module   : serial_alu_ctrl
// Brief    : Bit-serial AND/OR/XOR/ADD sequencer with looped-back carry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_alu_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] inA,
   input  logic [WIDTH-1:0] inB,
   input  logic             cin,
   input  logic             s1,
   input  logic             s0,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out,
   output logic             cout
);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_RUN  = 2'd1;
   localparam logic [1:0] c_DONE = 2'd2;

   localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic [1:0]       r_op;
   logic             r_carry;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_out;
   logic             r_cout;

   logic             w_bit;
   logic             w_carry;

   // One-bit select slice evaluated on the operand LSBs.
   always_comb begin
      w_bit   = 1'b0;
      w_carry = 1'b0;
      case (r_op)
         2'b00: w_bit = r_a[0] & r_b[0];
         2'b01: w_bit = r_a[0] | r_b[0];
         2'b10: w_bit = r_a[0] ^ r_b[0];
         default: begin
            w_bit   = r_a[0] ^ r_b[0] ^ r_carry;
            w_carry = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_op    <= 2'b00;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_out   <= '0;
         r_cout  <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (start) begin
                  r_a     <= inA;
                  r_b     <= inB;
                  r_op    <= {s1, s0};
                  r_carry <= s1 & s0 & cin;
                  r_cnt   <= '0;
                  r_res   <= '0;
                  r_state <= c_RUN;
               end
            end
            c_RUN: begin
               // Result bits enter at the MSB so bit i settles at position i.
               r_res   <= {w_bit, r_res[WIDTH-1:1]};
               r_a     <= r_a >> 1;
               r_b     <= r_b >> 1;
               r_carry <= w_carry;
               r_cnt   <= r_cnt + c_ONE;
               if (r_cnt == c_LAST) begin
                  r_out   <= {w_bit, r_res[WIDTH-1:1]};
                  r_cout  <= w_carry;
                  r_state <= c_DONE;
               end
            end
            c_DONE:  r_state <= c_IDLE;
            default: r_state <= c_IDLE;
         endcase
      end
   end

   assign busy = (r_state != c_IDLE);
   assign done = (r_state == c_DONE);
   assign out  = r_out;
   assign cout = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_serial_alu_ctrl.sv
// ============================================================================
// Module   : tb_serial_alu_ctrl
// Brief    : Directed self-checking bench for serial_alu_ctrl (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_alu_ctrl;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] inA;
   logic [7:0] inB;
   logic       cin;
   logic       s1;
   logic       s0;
   logic       busy;
   logic       done;
   logic [7:0] out;
   logic       cout;

   int checks   = 0;
   int failures = 0;
   logic [7:0] exp_prev = 8'h00;

   serial_alu_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .inA   (inA),
      .inB   (inB),
      .cin   (cin),
      .s1    (s1),
      .s0    (s0),
      .busy  (busy),
      .done  (done),
      .out   (out),
      .cout  (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Launch one op at a negedge, follow it to the done pulse and check
   // latency, busy length, result and that out holds the old value mid-run.
   task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic [1:0] op,
                         input logic [7:0] eo, input logic ec, input bit hold);
      int n;
      int nb;
      @(negedge clk);
      chk({tag, "_idle"}, 32'(busy), 32'd0);
      inA = a; inB = b; cin = ci; {s1, s0} = op; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (!hold) start = 1'b0;
      n  = 0;
      nb = 0;
      while (!done && n < 20) begin
         if (busy) nb++;
         if (n == 4) chk({tag, "_hold_out"}, 32'(out), 32'(exp_prev));
         if (hold) begin
            inA = 8'($urandom); inB = 8'($urandom); cin = ~cin; {s1, s0} = 2'($urandom);
         end
         @(negedge clk);
         n++;
      end
      if (busy) nb++;
      chk({tag, "_latency"}, 32'(n), 32'd8);
      chk({tag, "_busy"}, 32'(nb), 32'd9);
      chk({tag, "_out"}, 32'(out), 32'(eo));
      chk({tag, "_cout"}, 32'(cout), 32'(ec));
      exp_prev = eo;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; inA = 8'h00; inB = 8'h00; cin = 1'b0; s1 = 1'b0; s0 = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_out",  32'(out),  32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      rst_n = 1'b1;

      run_op("add1",  8'h5A, 8'h3C, 1'b0, 2'b11, 8'h96, 1'b0, 1'b0);
      run_op("addwr", 8'hFF, 8'h01, 1'b0, 2'b11, 8'h00, 1'b1, 1'b0);
      run_op("addci", 8'h00, 8'h00, 1'b1, 2'b11, 8'h01, 1'b0, 1'b0);
      run_op("and",   8'hF0, 8'h3C, 1'b1, 2'b00, 8'h30, 1'b0, 1'b0);
      run_op("or",    8'hF0, 8'h3C, 1'b1, 2'b01, 8'hFC, 1'b0, 1'b0);
      run_op("xor",   8'hF0, 8'h3C, 1'b1, 2'b10, 8'hCC, 1'b0, 1'b0);
      // start stays high with operands scrambled during RUN; the next op
      // must be accepted in the very first IDLE cycle.
      run_op("hold",  8'h5A, 8'h3C, 1'b0, 2'b11, 8'h96, 1'b0, 1'b1);
      run_op("b2b",   8'h0F, 8'h01, 1'b0, 2'b11, 8'h10, 1'b0, 1'b1);
      start = 1'b0;
      repeat (3) @(negedge clk);

      // Abort an ADD mid-run with an asynchronous reset.
      inA = 8'hAA; inB = 8'h55; cin = 1'b0; {s1, s0} = 2'b11; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_out",  32'(out),  32'd0);
      chk("abort_cout", 32'(cout), 32'd0);
      begin
         int seen = 0;
         for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) seen++;
         end
         chk("abort_nodone", 32'(seen), 32'd0);
      end
      rst_n = 1'b1;
      exp_prev = 8'h00;
      run_op("post", 8'h12, 8'h34, 1'b0, 2'b11, 8'h46, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/serial_alu_ctrl.md
Name: serial_alu_ctrl

Overview:
- Bit-serial multi-bit ALU built around the team's 1-bit select slice function (inA, inB, cin, s1, s0 -> out, cout).
- Latches two WIDTH-bit operands and an opcode, then feeds one bit pair per clock, LSB first.
- Carry is looped back between bits, and the serial outputs are assembled into a WIDTH-bit result.
- Sits directly upstream of the slice and provides its sequencing and carry chain.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2).
- CNT_W, 4, bit-counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- inA  input  WIDTH  operand A.
- inB  input  WIDTH  operand B.
- cin  input  1  initial carry-in (ADD only).
- s1  input  1  opcode bit 1.
- s0  input  1  opcode bit 0.
- busy  output  1  high while state != IDLE.
- done  output  1  one-cycle pulse; result/cout valid.
- out  output  WIDTH  assembled result.
- cout  output  1  final carry-out.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. All state is cleared immediately on assertion, independent of clk.
- Reset values: state=IDLE, busy=0, done=0, out=0, cout=0, bit counter=0, internal operand/carry registers=0.
- Per-bit function, fixed encoding {s1,s0}, with a=A[i], b=B[i], c=running carry:
  - 00 AND: o=a&b, carry'=0.
  - 01 OR: o=a|b, carry'=0.
  - 10 XOR: o=a^b, carry'=0.
  - 11 ADD: o=a^b^c, carry'=(a&b)|(c&(a^b)).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0: latch inA, inB, {s1,s0} into internal registers.
  - Load carry with cin for ADD, 0 otherwise. Set counter=0. Go to RUN.
  - Inputs are not sampled again until the next acceptance.
- RUN, each edge E1..E_WIDTH:
  - Compute the bit on the A/B shift-register LSBs and the carry.
  - Shift the result bit in at the MSB of the result shift register (after WIDTH shifts, bit i lands in position i).
  - Shift A and B right, update carry, increment counter.
  - On the edge where counter==WIDTH-1: copy the final result to out and the final carry to cout, then go to DONE.
- DONE:
  - done=1 for exactly one cycle, decoded from state.
  - Next edge returns to IDLE.
- Latency: done is high in the cycle after edge E_WIDTH, i.e. WIDTH cycles after the accepting edge.
  - Throughput: one operation per WIDTH+2 cycles (start accepted again in the first IDLE cycle).
- busy is high throughout RUN and DONE; low in IDLE.
- out and cout change only when updated at the end of RUN, and hold until the next operation completes. They do not show partial results mid-operation.
- start while busy (RUN or DONE) is ignored and not queued.
- start held high continuously: a new operation is accepted on each IDLE cycle, giving back-to-back ops every WIDTH+2 cycles.
- Input changes on inA/inB/cin/s1/s0 during RUN have no effect.
- Reset mid-operation: abort immediately, clear per reset values, no done pulse. Next start is accepted normally.
- Carry for logic ops is forced 0, so cout=0 for AND/OR/XOR regardless of cin.

Test Plan:
- ADD {s1,s0}=11, inA=0x5A, inB=0x3C, cin=0, pulse start -> done pulse exactly 8 cycles after the accepting edge; out=0x96, cout=0; busy high for 9 cycles.
- ADD wrap: inA=0xFF, inB=0x01, cin=0 -> out=0x00, cout=1. Then inA=0x00, inB=0x00, cin=1 -> out=0x01, cout=0.
- Logic ops with inA=0xF0, inB=0x3C, cin=1 -> AND out=0x30, OR out=0xFC, XOR out=0xCC; cout=0 each time.
- start held high through an ADD while inA/inB toggle during RUN -> result reflects latched operands only; extra starts are ignored; next op is accepted on the first IDLE cycle.
- Deassert rst_n asynchronously at bit 4 of an ADD -> busy/done/out/cout drop to 0 immediately, no done pulse; a subsequent ADD 0x12+0x34 yields out=0x46, cout=0.
